cp0_exception_unit: RTL and testbench

- Coprocessor-0 block that sits beside the M stage and drives the pipeline-wide flush request `Req`.
- The M/W pipeline register consumes `Req` and redirects W to the handler at 0x4180.
- Holds SR, Cause, EPC and PRId; detects interrupts and exceptions; captures the victim PC; services mfc0, mtc0 and eret.
- Sequential state: the architectural registers plus the EXL mode bit that gates further requests.

---
 rtl/cp0_exception_unit.sv | 108 ++++++++++
 tb/tb_cp0_exception_unit.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_exception_unit.sv
// Coprocessor-0 exception unit.
// Holds SR, Cause, EPC and PRId. Raises the pipeline-wide flush request Req
// when an enabled interrupt or an M-stage exception is seen outside the
// handler, captures the victim PC, and services mfc0 / mtc0 / eret.
module cp0_exception_unit #(
  parameter logic [31:0] PRID    = 32'h0000_0820,
  parameter int          HWINT_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [4:0]         A1,
  input  logic [4:0]         A2,
  input  logic [31:0]        DIn,
  input  logic               EN,
  input  logic [31:0]        M_PC,
  input  logic               BDIn,
  input  logic [4:0]         ExcCodeIn,
  input  logic [HWINT_W-1:0] HWInt,
  input  logic               EXLClr,
  output logic               Req,
  output logic [31:0]        EPCOut,
  output logic [31:0]        DOut
);

  // SR fields
  logic [HWINT_W-1:0] im;
  logic               exl;
  logic               ie;
  // Cause fields
  logic               bd;
  logic [HWINT_W-1:0] ip;
  logic [4:0]         exc_code;
  // EPC
  logic [31:0]        epc;

  logic               int_req;
  logic               exc_req;
  logic [31:0]        victim_pc;
  logic [31:0]        sr_word;
  logic [31:0]        cause_word;

  // Request detection; EXL blocks nested requests, and Req is held low while
  // reset is asserted so a stale ExcCodeIn cannot flush during reset.
  always_comb begin
    int_req   = (|(HWInt & im)) & ie & ~exl;
    exc_req   = (ExcCodeIn != 5'd0) & ~exl;
    Req       = (int_req | exc_req) & reset;
    victim_pc = BDIn ? (M_PC - 32'd4) : M_PC;
  end

  // Status register: exception entry, then eret, then mtc0 write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im  <= '0;
      exl <= 1'b0;
      ie  <= 1'b0;
    end else if (Req) begin
      exl <= 1'b1;
    end else if (EXLClr) begin
      exl <= 1'b0;
    end else if (EN && (A2 == 5'd12)) begin
      im  <= DIn[15:10];
      exl <= DIn[1];
      ie  <= DIn[0];
    end
  end

  // Cause register: ExcCode/BD captured on entry, IP samples HWInt every cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bd       <= 1'b0;
      ip       <= '0;
      exc_code <= '0;
    end else begin
      ip <= HWInt;
      if (Req) begin
        bd       <= BDIn;
        exc_code <= int_req ? 5'd0 : ExcCodeIn;
      end
    end
  end

  // EPC: victim PC on entry (word aligned), otherwise mtc0 writes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      epc <= '0;
    end else if (Req) begin
      epc <= {victim_pc[31:2], 2'b00};
    end else if (!EXLClr && EN && (A2 == 5'd14)) begin
      epc <= {DIn[31:2], 2'b00};
    end
  end

  // Register images and the mfc0 read mux (no write-to-read bypass).
  always_comb begin
    sr_word    = {16'd0, im, 8'd0, exl, ie};
    cause_word = {bd, 15'd0, ip, 3'd0, exc_code, 2'd0};
    EPCOut     = epc;
    case (A1)
      5'd12:   DOut = sr_word;
      5'd13:   DOut = cause_word;
      5'd14:   DOut = epc;
      5'd15:   DOut = PRID;
      default: DOut = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Directed bench for cp0_exception_unit. Inputs change 1 time unit after a
// rising edge; combinational outputs are checked 1 unit after inputs change.
module tb_cp0_exception_unit;

  logic        clk;
  logic        reset;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        EN;
  logic [31:0] M_PC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic        Req;
  logic [31:0] EPCOut;
  logic [31:0] DOut;

  int checks;
  int errors;

  cp0_exception_unit dut (
    .clk       (clk),
    .reset     (reset),
    .A1        (A1),
    .A2        (A2),
    .DIn       (DIn),
    .EN        (EN),
    .M_PC      (M_PC),
    .BDIn      (BDIn),
    .ExcCodeIn (ExcCodeIn),
    .HWInt     (HWInt),
    .EXLClr    (EXLClr),
    .Req       (Req),
    .EPCOut    (EPCOut),
    .DOut      (DOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    A1 = 5'd0; A2 = 5'd0; DIn = 32'd0; EN = 1'b0; M_PC = 32'd0;
    BDIn = 1'b0; ExcCodeIn = 5'd0; HWInt = 6'd0; EXLClr = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    A2 = a; DIn = d; EN = 1'b1;
    tick();
    EN = 1'b0; A2 = 5'd0; DIn = 32'd0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_rd [0:4];
    logic [4:0]  addr   [0:4];
    reset = 1'b0;
    idle_inputs();
    repeat (3) tick();
    reset = 1'b1;
    tick();
    addr[0] = 5'd12; exp_rd[0] = 32'h0;
    addr[1] = 5'd13; exp_rd[1] = 32'h0;
    addr[2] = 5'd14; exp_rd[2] = 32'h0;
    addr[3] = 5'd15; exp_rd[3] = 32'h0000_0820;
    addr[4] = 5'd3;  exp_rd[4] = 32'h0;
    for (int i = 0; i < 5; i++) begin
      A1 = addr[i];
      #1;
      checks++;
      if (DOut !== exp_rd[i]) begin
        errors++;
        $display("FAIL reset_read a1=%0d got=%h exp=%h", addr[i], DOut, exp_rd[i]);
      end
    end
    checks++;
    if (Req !== 1'b0) begin
      errors++;
      $display("FAIL reset_req got=%b exp=0", Req);
    end
    checks++;
    if (EPCOut !== 32'h0) begin
      errors++;
      $display("FAIL reset_epcout got=%h exp=0", EPCOut);
    end
  endtask

  task automatic test_interrupt();
    mtc0(5'd12, 32'h0000_FC01);
    A1 = 5'd12; #1;
    checks++;
    if (DOut !== 32'h0000_FC01) begin
      errors++;
      $display("FAIL int_sr_write got=%h exp=0000fc01", DOut);
    end
    HWInt = 6'b000100; M_PC = 32'h3010; BDIn = 1'b0;
    #1;
    checks++;
    if (Req !== 1'b1) begin
      errors++;
      $display("FAIL int_req got=%b exp=1", Req);
    end
    tick();
    checks++;
    if (Req !== 1'b0) begin
      errors++;
      $display("FAIL int_req_exl_gated got=%b exp=0", Req);
    end
    A1 = 5'd12; #1;
    checks++;
    if (DOut !== 32'h0000_FC03) begin
      errors++;
      $display("FAIL int_sr_exl got=%h exp=0000fc03", DOut);
    end
    A1 = 5'd13; #1;
    checks++;
    if (DOut !== 32'h0000_1000) begin
      errors++;
      $display("FAIL int_cause got=%h exp=00001000", DOut);
    end
    A1 = 5'd14; #1;
    checks++;
    if (DOut !== 32'h0000_3010 || EPCOut !== 32'h0000_3010) begin
      errors++;
      $display("FAIL int_epc got=%h/%h exp=00003010", DOut, EPCOut);
    end
    HWInt = 6'd0; EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;
    A1 = 5'd12; #1;
    checks++;
    if (DOut !== 32'h0000_FC01) begin
      errors++;
      $display("FAIL int_eret_sr got=%h exp=0000fc01", DOut);
    end
    A1 = 5'd13; #1;
    checks++;
    if (DOut !== 32'h0) begin
      errors++;
      $display("FAIL int_ip_follow got=%h exp=00000000", DOut);
    end
  endtask

  task automatic test_exception_bd();
    ExcCodeIn = 5'd4; M_PC = 32'h3024; BDIn = 1'b1;
    #1;
    checks++;
    if (Req !== 1'b1) begin
      errors++;
      $display("FAIL exc_req got=%b exp=1", Req);
    end
    tick();
    checks++;
    if (Req !== 1'b0) begin
      errors++;
      $display("FAIL exc_req_exl_gated got=%b exp=0", Req);
    end
    checks++;
    if (EPCOut !== 32'h0000_3020) begin
      errors++;
      $display("FAIL exc_epc_bd got=%h exp=00003020", EPCOut);
    end
    A1 = 5'd13; #1;
    checks++;
    if (DOut !== 32'h8000_0010) begin
      errors++;
      $display("FAIL exc_cause got=%h exp=80000010", DOut);
    end
    ExcCodeIn = 5'd0; BDIn = 1'b0; M_PC = 32'h0;
    EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;
  endtask

  task automatic test_back_to_back();
    ExcCodeIn = 5'd10; M_PC = 32'h4000; BDIn = 1'b0;
    EN = 1'b1; A2 = 5'd14; DIn = 32'h5000;
    tick();
    EN = 1'b0; ExcCodeIn = 5'd0;
    checks++;
    if (EPCOut !== 32'h0000_4000) begin
      errors++;
      $display("FAIL collide_epc got=%h exp=00004000", EPCOut);
    end
    A1 = 5'd13; #1;
    checks++;
    if (DOut !== 32'h0000_0028) begin
      errors++;
      $display("FAIL collide_cause got=%h exp=00000028", DOut);
    end
    EXLClr = 1'b1; EN = 1'b1; A2 = 5'd12; DIn = 32'h0;
    tick();
    EXLClr = 1'b0; EN = 1'b0;
    A1 = 5'd12; #1;
    checks++;
    if (DOut !== 32'h0000_FC01) begin
      errors++;
      $display("FAIL eret_vs_mtc0 got=%h exp=0000fc01", DOut);
    end
  endtask

  task automatic test_mtc0_targets();
    mtc0(5'd13, 32'hFFFF_FFFF);
    A1 = 5'd13; #1;
    checks++;
    if (DOut !== 32'h0000_0028) begin
      errors++;
      $display("FAIL mtc0_cause_ro got=%h exp=00000028", DOut);
    end
    mtc0(5'd15, 32'h1234_5678);
    A1 = 5'd15; #1;
    checks++;
    if (DOut !== 32'h0000_0820) begin
      errors++;
      $display("FAIL mtc0_prid_ro got=%h exp=00000820", DOut);
    end
    A2 = 5'd14; DIn = 32'h3007; EN = 1'b1; A1 = 5'd14;
    #1;
    checks++;
    if (DOut !== 32'h0000_4000 || EPCOut !== 32'h0000_4000) begin
      errors++;
      $display("FAIL epc_no_bypass got=%h/%h exp=00004000", DOut, EPCOut);
    end
    tick();
    EN = 1'b0;
    checks++;
    if (EPCOut !== 32'h0000_3004) begin
      errors++;
      $display("FAIL mtc0_epc_align got=%h exp=00003004", EPCOut);
    end
  endtask

  task automatic test_masking();
    mtc0(5'd12, 32'h0000_0001);
    HWInt = 6'h3F; #1;
    checks++;
    if (Req !== 1'b0) begin
      errors++;
      $display("FAIL mask_im_zero got=%b exp=0", Req);
    end
    mtc0(5'd12, 32'h0000_FC00);
    #1;
    checks++;
    if (Req !== 1'b0) begin
      errors++;
      $display("FAIL mask_ie_zero got=%b exp=0", Req);
    end
    mtc0(5'd12, 32'hFFFF_FFFF);
    A1 = 5'd12; #1;
    checks++;
    if (DOut !== 32'h0000_FC03) begin
      errors++;
      $display("FAIL sr_write_mask got=%h exp=0000fc03", DOut);
    end
    checks++;
    if (Req !== 1'b0) begin
      errors++;
      $display("FAIL exl_blocks_int got=%b exp=0", Req);
    end
    HWInt = 6'd0;
  endtask

  task automatic test_reset_mid_handler();
    ExcCodeIn = 5'd3; M_PC = 32'h0000_0002; BDIn = 1'b1;
    reset = 1'b0; A1 = 5'd12; #1;
    checks++;
    if (DOut !== 32'h0 || Req !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_handler sr=%h req=%b exp=00000000/0", DOut, Req);
    end
    tick();
    reset = 1'b1; #1;
    checks++;
    if (Req !== 1'b1) begin
      errors++;
      $display("FAIL req_after_reset got=%b exp=1", Req);
    end
    tick();
    ExcCodeIn = 5'd0; BDIn = 1'b0;
    checks++;
    if (EPCOut !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL epc_wrap got=%h exp=fffffffc", EPCOut);
    end
    A1 = 5'd13; #1;
    checks++;
    if (DOut !== 32'h8000_000C) begin
      errors++;
      $display("FAIL wrap_cause got=%h exp=8000000c", DOut);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_interrupt();
    test_exception_bd();
    test_back_to_back();
    test_mtc0_targets();
    test_masking();
    test_reset_mid_handler();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
